// File: rtl/dac_ref_slew_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_pkg
// Description : Shared types and constants for the DAC reference slew limiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

    typedef enum logic {
        SETTLED = 1'b0,
        SLEWING = 1'b1
    } slew_state_t;

    localparam int LEVEL_W = 8;

    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dac_ref_slew_if.sv
`default_nettype none
// ============================================================================
// Module      : dac_ref_slew_if
// Description : Target-write handshake between the register block and the
//               reference slew limiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_ref_slew_if;
    import dac_pkg::*;

    logic               wr_valid;
    logic               wr_ready;
    logic               wr_channel;
    logic [LEVEL_W-1:0] wr_level;

    modport master (
        output wr_valid,
        output wr_channel,
        output wr_level,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_channel,
        input  wr_level,
        output wr_ready
    );

endinterface
`default_nettype wire

// File: rtl/dac_ref_slew_channel.sv
`default_nettype none
// ============================================================================
// Module      : dac_ref_channel
// Description : One DAC channel: target and active level registers, slew FSM
//               and the bounded step toward the target.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_ref_channel
    import dac_pkg::*;
#(
    parameter int                 MAX_STEP    = 8,
    parameter logic [LEVEL_W-1:0] RESET_LEVEL = '0
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    input  wire logic               wr_en,
    input  wire logic [LEVEL_W-1:0] wr_level,
    input  wire logic               step_en,
    output logic      [LEVEL_W-1:0] active,
    output logic                    slewing,
    output logic                    settled
);

    localparam logic [0:0]         ST_SETTLED = SETTLED;
    localparam logic [0:0]         ST_SLEWING = SLEWING;
    localparam logic [LEVEL_W-1:0] STEP_N     = LEVEL_W'(MAX_STEP);
    localparam logic [LEVEL_W:0]   STEP_W     = (LEVEL_W+1)'(MAX_STEP);

    logic [LEVEL_W-1:0]        target_q;
    logic [LEVEL_W-1:0]        target_d;
    logic [LEVEL_W-1:0]        active_q;
    logic [LEVEL_W-1:0]        active_d;
    logic [0:0]                state_q;
    logic [0:0]                state_d;
    logic                      settled_q;
    logic                      settled_d;
    logic signed [LEVEL_W:0]   diff;
    logic [LEVEL_W:0]          abs_diff;
    logic [LEVEL_W-1:0]        step_val;

    // Distance to target; both operands are zero-extended so no wrap occurs.
    assign diff     = $signed({1'b0, target_q}) - $signed({1'b0, active_q});
    assign abs_diff = diff[LEVEL_W] ? $unsigned(-diff) : $unsigned(diff);

    // Bounded step: jump straight to target when close enough or unlimited.
    always_comb begin
        step_val = target_q;
        if ((MAX_STEP != 0) && (abs_diff > STEP_W)) begin
            if (diff[LEVEL_W]) begin
                step_val = active_q - STEP_N;
            end else begin
                step_val = active_q + STEP_N;
            end
        end
    end

    // Next state: the step uses the old target, a same-edge write lands after it.
    always_comb begin
        active_d  = step_en ? step_val : active_q;
        target_d  = wr_en ? wr_level : target_q;
        state_d   = (active_d != target_d) ? ST_SLEWING : ST_SETTLED;
        settled_d = (state_q == ST_SLEWING) && (state_d == ST_SETTLED);
    end

    // Channel registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q  <= RESET_LEVEL;
            active_q  <= RESET_LEVEL;
            state_q   <= ST_SETTLED;
            settled_q <= 1'b0;
        end else begin
            target_q  <= target_d;
            active_q  <= active_d;
            state_q   <= state_d;
            settled_q <= settled_d;
        end
    end

    assign active  = active_q;
    assign slewing = (state_q == ST_SLEWING);
    assign settled = settled_q;

endmodule
`default_nettype wire

// File: rtl/dac_ref_slew.sv
`default_nettype none
// ============================================================================
// Module      : dac_ref_slew
// Description : Slew-limited two-channel reference level source feeding the
//               SPI DAC write path. Levels only move at SPI frame ends.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_ref_slew
    import dac_pkg::*;
#(
    parameter int                 MAX_STEP    = 8,
    parameter logic [LEVEL_W-1:0] RESET_LEVEL = '0
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    dac_ref_slew_if.slave           wr,
    input  wire logic               cs_n,
    input  wire logic               channel_sel,
    output logic      [LEVEL_W-1:0] ref_level,
    output logic                    busy,
    output logic      [1:0]         settled
);

    logic               cs_n_q;
    logic               chan_q;
    logic               ready_q;
    logic               frame_done;
    logic               wr_fire;
    logic [1:0]         wr_en;
    logic [1:0]         step_en;
    logic [1:0]         slewing;
    logic [LEVEL_W-1:0] active [2];

    // Frame-end detector and ready flag; cs_n_q resets high so no frame end
    // can be seen on the first edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_n_q  <= 1'b1;
            chan_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            cs_n_q  <= cs_n;
            chan_q  <= channel_sel;
            ready_q <= 1'b1;
        end
    end

    assign frame_done  = ~cs_n_q & cs_n;
    assign wr.wr_ready = ready_q;
    assign wr_fire     = wr.wr_valid & ready_q;

    generate
        for (genvar c = 0; c < 2; c++) begin : g_ch
            assign wr_en[c]   = wr_fire & (wr.wr_channel == 1'(c));
            assign step_en[c] = frame_done & (chan_q == 1'(c));

            dac_ref_channel #(
                .MAX_STEP    (MAX_STEP),
                .RESET_LEVEL (RESET_LEVEL)
            ) u_channel (
                .clk      (clk),
                .reset_n  (reset_n),
                .wr_en    (wr_en[c]),
                .wr_level (wr.wr_level),
                .step_en  (step_en[c]),
                .active   (active[c]),
                .slewing  (slewing[c]),
                .settled  (settled[c])
            );
        end
    endgenerate

    assign ref_level = (channel_sel == CH2) ? active[1] : active[0];
    assign busy      = |slewing;

endmodule
`default_nettype wire
